weighted_sum_n: RTL and testbench

WEIGHTED_SUM_N -- requirements
Module: weighted_sum_n

---
 rtl/weighted_sum_n.sv | 145 ++++++++++++++
 tb/tb_weighted_sum_n.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weighted_sum_n.sv
// weighted_sum_n: Horner-evaluated weighted sum of N_CH signed fixed-point samples, one step per cycle.
// Define WEIGHTED_SUM_SAT_EN to clamp products and sums (sticky out_sat); otherwise results wrap.
module weighted_sum_n #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 16,
  parameter int FRAC_W = 14
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_CH*DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0]      mu_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      data_out,
  output logic                   out_sat
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);

  logic [1:0]                 state, state_nxt;
  logic [N_CH*DATA_W-1:0]     data_r;
  logic signed [DATA_W-1:0]   mu_r;
  logic signed [DATA_W-1:0]   acc, acc_nxt;
  logic [IDX_W-1:0]           idx, idx_nxt;
  logic signed [DATA_W-1:0]   sample;
  logic signed [2*DATA_W-1:0] acc_ext, mu_ext, prod;
  logic signed [DATA_W-1:0]   prod_trunc, prod_red, step_val;
  logic signed [DATA_W:0]     sum;
  logic                       accept;
  logic                       unused_bits;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_ready & in_valid;

  // NOTE: combinational blocks use blocking '=' and give every output a default first, so no latch is inferred.
  always_comb begin
    sample = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (idx == IDX_W'(k)) sample = data_r[k*DATA_W +: DATA_W];
    end
  end

  // Full-width signed product; the Q-format result is the DATA_W-bit window above FRAC_W.
  assign acc_ext    = {{DATA_W{acc[DATA_W-1]}}, acc};
  assign mu_ext     = {{DATA_W{mu_r[DATA_W-1]}}, mu_r};
  assign prod       = acc_ext * mu_ext;
  assign prod_trunc = prod[FRAC_W+DATA_W-1:FRAC_W];
  assign sum        = {prod_red[DATA_W-1], prod_red} + {sample[DATA_W-1], sample};

`ifdef WEIGHTED_SUM_SAT_EN
  localparam int HI_W = DATA_W - FRAC_W + 1;
  localparam logic signed [DATA_W-1:0] MAX_VAL = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};

  logic [HI_W-1:0] prod_hi;
  logic            prod_ovf, sum_ovf, step_sat;
  logic            sat_r, sat_nxt;

  // The product fits DATA_W only if every bit from the window's sign bit upward agrees.
  assign prod_hi     = prod[2*DATA_W-1 -: HI_W];
  assign prod_ovf    = ~((&prod_hi) | ~(|prod_hi));
  assign prod_red    = prod_ovf ? (prod[2*DATA_W-1] ? MIN_VAL : MAX_VAL) : prod_trunc;
  assign sum_ovf     = sum[DATA_W] ^ sum[DATA_W-1];
  assign step_val    = sum_ovf ? (sum[DATA_W] ? MIN_VAL : MAX_VAL) : sum[DATA_W-1:0];
  assign step_sat    = prod_ovf | sum_ovf;
  assign unused_bits = ^prod[FRAC_W-1:0];

  always_comb begin
    sat_nxt = sat_r;
    if (accept)              sat_nxt = 1'b0;
    else if (state == CALC)  sat_nxt = sat_r | step_sat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_r   <= 1'b0;
      out_sat <= 1'b0;
    end else begin
      sat_r <= sat_nxt;
      if (state_nxt == DONE) out_sat <= sat_nxt;
    end
  end
`else
  assign prod_red    = prod_trunc;
  assign step_val    = sum[DATA_W-1:0];
  assign out_sat     = 1'b0;
  assign unused_bits = ^{prod[2*DATA_W-1:FRAC_W+DATA_W], prod[FRAC_W-1:0], sum[DATA_W]};
`endif

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    idx_nxt   = idx;
    case (state)
      IDLE: begin
        if (in_valid) begin
          acc_nxt   = data_in[DATA_W-1:0];
          idx_nxt   = IDX_W'(1);
          state_nxt = (N_CH == 1) ? DONE : CALC;
        end
      end
      CALC: begin
        acc_nxt = step_val;
        idx_nxt = idx + IDX_W'(1);
        if (idx == LAST_IDX) state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= '0;
      idx      <= '0;
      // NOTE: the operand registers are reset as well; they are few flops and keep the idle datapath free of X.
      data_r   <= '0;
      mu_r     <= '0;
      data_out <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      idx   <= idx_nxt;
      if (accept) begin
        data_r <= data_in;
        mu_r   <= mu_in;
      end
      // data_out only moves on entry to DONE, so it holds its last value everywhere else.
      if (state_nxt == DONE) data_out <= acc_nxt;
    end
  end

endmodule

// File: tb/tb_weighted_sum_n.sv
// Self-checking bench for weighted_sum_n: cycle-level reference model plus directed vectors.
// Covers the N_CH=4 build and a second N_CH=1 instance; honours WEIGHTED_SUM_SAT_EN when defined.
`timescale 1ns/1ps
module tb_weighted_sum_n;

  localparam int N_CH   = 4;
  localparam int DATA_W = 16;
  localparam int FRAC_W = 14;

  localparam longint ONE  = longint'(1) << FRAC_W;
  localparam longint SPAN = longint'(1) << DATA_W;
  localparam longint MAXV = SPAN / 2 - 1;
  localparam longint MINV = -(SPAN / 2);

`ifdef WEIGHTED_SUM_SAT_EN
  localparam longint EXP_BIG  = 32767;
  localparam bit     SAT_BIG  = 1'b1;
  localparam longint EXP_POVF = -32768;
  localparam bit     SAT_POVF = 1'b1;
`else
  localparam longint EXP_BIG  = -32768;
  localparam bit     SAT_BIG  = 1'b0;
  localparam longint EXP_POVF = 0;
  localparam bit     SAT_POVF = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b1;
  logic                   in_valid = 1'b0;
  logic                   out_ready = 1'b0;
  logic [N_CH*DATA_W-1:0] data_in = '0;
  logic [DATA_W-1:0]      mu_in = '0;
  logic                   in_ready, out_valid, out_sat;
  logic [DATA_W-1:0]      data_out;

  logic                   in_valid1 = 1'b0;
  logic                   out_ready1 = 1'b0;
  logic [DATA_W-1:0]      data_in1 = '0;
  logic [DATA_W-1:0]      mu_in1 = '0;
  logic                   in_ready1, out_valid1, out_sat1;
  logic [DATA_W-1:0]      data_out1;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  weighted_sum_n #(.N_CH(N_CH), .DATA_W(DATA_W), .FRAC_W(FRAC_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .mu_in(mu_in), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .out_sat(out_sat)
  );

  weighted_sum_n #(.N_CH(1), .DATA_W(DATA_W), .FRAC_W(FRAC_W)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .data_in(data_in1), .mu_in(mu_in1), .out_valid(out_valid1), .out_ready(out_ready1),
    .data_out(data_out1), .out_sat(out_sat1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model: plain integer arithmetic ----------------
  typedef struct packed { longint val; bit sat; } res_t;

  function automatic longint fit(input longint x, inout bit sat);
    longint r;
    r = x;
`ifdef WEIGHTED_SUM_SAT_EN
    if (x > MAXV) begin r = MAXV; sat = 1'b1; end
    else if (x < MINV) begin r = MINV; sat = 1'b1; end
`else
    r = ((x % SPAN) + SPAN) % SPAN;
    if (r > MAXV) r = r - SPAN;
`endif
    return r;
  endfunction

  function automatic longint floor_scale(input longint p);
    longint q;
    q = p / ONE;
    if (p < 0 && q * ONE != p) q = q - 1;
    return q;
  endfunction

  function automatic res_t model_sum(input logic [N_CH*DATA_W-1:0] v, input logic [DATA_W-1:0] mu);
    res_t   r;
    longint acc, m;
    bit     s;
    s   = 1'b0;
    m   = longint'($signed(mu));
    acc = longint'($signed(v[DATA_W-1:0]));
    for (int k = 1; k < N_CH; k++) begin
      acc = fit(floor_scale(acc * m), s);
      acc = fit(acc + longint'($signed(v[k*DATA_W +: DATA_W])), s);
    end
    r.val = acc;
    r.sat = s;
    return r;
  endfunction

  res_t now_res, m_res;
  res_t m_out = '0;
  bit   m_busy = 1'b0;
  bit   m_done = 1'b0;
  int   m_left = 0;

  always_comb now_res = model_sum(data_in, mu_in);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_left <= 0;
      m_out  <= '0;
    end else if (m_done) begin
      if (out_ready) m_done <= 1'b0;
    end else if (m_busy) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_out  <= m_res;
      end
    end else if (in_valid) begin
      m_res  <= now_res;
      m_left <= N_CH - 1;
      if (N_CH == 1) begin
        m_done <= 1'b1;
        m_out  <= now_res;
      end else begin
        m_busy <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc in_ready", longint'(in_ready), longint'(!(m_busy || m_done)));
      check("cyc out_valid", longint'(out_valid), longint'(m_done));
      check("cyc data_out", longint'($signed(data_out)), m_out.val);
      check("cyc out_sat", longint'(out_sat), longint'(m_out.sat));
    end
  end

  // ---------------- directed stimulus ----------------
  function automatic logic [N_CH*DATA_W-1:0] pack(input int d0, input int d1, input int d2, input int d3);
    return {DATA_W'(d3), DATA_W'(d2), DATA_W'(d1), DATA_W'(d0)};
  endfunction

  // Called just after a rising edge with the DUT idle; returns just after the accepting edge.
  task automatic send(input logic [N_CH*DATA_W-1:0] v, input int mu);
    data_in  = v;
    mu_in    = DATA_W'(mu);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic await_result(input string name, input longint exp_val, input bit exp_sat);
    int cyc;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!out_valid && cyc < 40);
    check({name, " latency"}, longint'(cyc), longint'(N_CH));
    check({name, " value"}, longint'($signed(data_out)), exp_val);
    check({name, " sat"}, longint'(out_sat), longint'(exp_sat));
  endtask

  task automatic consume;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    // A vector is already waiting while reset is applied.
    data_in  = pack(24576, 24576, 24576, 24576);
    mu_in    = DATA_W'(16384);
    in_valid = 1'b1;
    #1;
    rst_n  = 1'b0;
    cmp_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst in_ready", longint'(in_ready), 1);
    check("rst out_valid", longint'(out_valid), 0);
    check("rst data_out", longint'($signed(data_out)), 0);
    check("rst n1 in_ready", longint'(in_ready1), 1);
    check("rst n1 out_valid", longint'(out_valid1), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    await_result("big", EXP_BIG, SAT_BIG);
    consume();

    send(pack(8192, 8192, 8192, 8192), 8192);
    await_result("half", 15360, 1'b0);
    consume();

    send(pack(16384, 0, 0, 0), -8192);
    await_result("neg_mu", -2048, 1'b0);
    consume();

    send(pack(-100, 0, 0, 0), 16383);
    await_result("floor", -100, 1'b0);
    consume();

    send(pack(16384, 0, 0, 0), -32768);
    await_result("prod_ovf", EXP_POVF, SAT_POVF);
    consume();

    // Backpressure: result held, new input ignored while out_ready is low.
    send(pack(1000, 2000, 3000, 4000), 16384);
    await_result("hold", 10000, 1'b0);
    data_in  = pack(1, 1, 1, 1);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold out_valid", longint'(out_valid), 1);
      check("hold data_out", longint'($signed(data_out)), 10000);
      check("hold in_ready", longint'(in_ready), 0);
    end
    in_valid = 1'b0;
    consume();
    @(negedge clk);
    check("release in_ready", longint'(in_ready), 1);
    check("release out_valid", longint'(out_valid), 0);
    check("release data_out", longint'($signed(data_out)), 10000);

    // Reset in the middle of a computation.
    @(posedge clk); #1;
    send(pack(8192, 8192, 8192, 8192), 8192);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst out_valid", longint'(out_valid), 0);
    check("midrst data_out", longint'($signed(data_out)), 0);
    check("midrst out_sat", longint'(out_sat), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("postrst in_ready", longint'(in_ready), 1);
    @(posedge clk); #1;
    send(pack(8192, 8192, 8192, 8192), 8192);
    await_result("postrst", 15360, 1'b0);
    consume();

    // Single-channel instance: result is channel 0 one cycle after acceptance.
    data_in1  = DATA_W'(1234);
    mu_in1    = DATA_W'(-5000);
    in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    @(negedge clk);
    check("n1 out_valid", longint'(out_valid1), 1);
    check("n1 data_out", longint'($signed(data_out1)), 1234);
    check("n1 out_sat", longint'(out_sat1), 0);
    check("n1 in_ready busy", longint'(in_ready1), 0);
    out_ready1 = 1'b1;
    @(posedge clk); #1;
    out_ready1 = 1'b0;
    @(negedge clk);
    check("n1 in_ready after", longint'(in_ready1), 1);
    check("n1 out_valid after", longint'(out_valid1), 0);

    @(posedge clk); #1;
    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
